matrix_cmd_seq: RTL and testbench
=================================

// Module: matrix_cmd_seq
// PURPOSE
//  Command sequencer directly upstream of the matrix stack controller. Accepts matrix
//  commands and a 32-bit float word stream over valid/ready handshakes. Packs 16 words
//  into four 128-bit rows and drives the controller's strobe/row protocol.
//  Owns the matrix_mode register and tracks per-stack depth to block overflow/underflow.
// PARAMETERS
//  STACK_DEPTH  2   matrices per stack (controller holds 8 rows = 2 matrices); range 1..2
// PORTS
//  clk          in   1    single clock
//  reset        in   1    asynchronous, active-low reset (asserted when 0)
//  cmd_valid    in   1    command present
//  cmd_ready    out  1    sequencer accepts command this cycle
//  cmd_op       in   3    0 NOP,1 MODE_MV,2 MODE_PJ,3 LOAD_ID,4 LOAD,5 POP,6-7 reserved
//  word_valid   in   1    matrix word present
//  word_ready   out  1    sequencer accepts word this cycle
//  word_data    in   32   IEEE-754 single, row-major, 16 words per LOAD
//  matrix_mode  out  1    0 modelview, 1 projection; to controller
//  load_id_en   out  1    1-cycle strobe to controller
//  load_en      out  1    1-cycle strobe, first cycle of a 4-cycle row burst
//  pop_en       out  1    1-cycle strobe to controller
//  data_in      out  128  row bus to controller
//  busy         out  1    high whenever state != IDLE
//  err          out  1    1-cycle pulse on rejected or reserved command
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0, async) -> state IDLE; matrix_mode=0;
//    strobes/err=0; data_in=0; cmd_ready=1; word_ready=0; busy=0. Both depth counters=1.
//    Row buffer contents are discarded.
//  - Reset mid-LOAD (COLLECT or ISSUE) abandons the command; no further strobes are driven.
//  - States: IDLE, PULSE, COLLECT, ISSUE (2-bit row counter r).
//  - cmd_ready=1 only in IDLE; word_ready=1 only in COLLECT. Handshake: valid&&ready.
//  - Words offered outside COLLECT are ignored (not consumed).
//  - IDLE, cmd accepted at cycle t:
//    NOP: no effect; stay IDLE.
//    MODE_MV/MODE_PJ: matrix_mode=0/1 from t+1; stay IDLE.
//    LOAD_ID: PULSE at t+1 with load_id_en=1; IDLE at t+2.
//    POP: if depth[mode]>1, PULSE at t+1 with pop_en=1 and depth[mode]-1.
//      Else err=1 at t+1, no pop_en, stay IDLE.
//    LOAD: COLLECT from t+1; word counter k=0.
//    reserved: err=1 at t+1; stay IDLE.
//  - COLLECT: each word handshake stores word k at row k/4, lane k%4. Lane 0 -> [127:96],
//    lane 3 -> [31:0]. k increments. Word_valid gaps stall indefinitely.
//  - After 16th word at cycle u:
//    if depth[mode]<STACK_DEPTH, ISSUE at u+1..u+4 with data_in=row r, r=0..3.
//      load_en=1 only at u+1. depth[mode]+1 at u+1. IDLE at u+5.
//    else err=1 at u+1, IDLE at u+1; all 16 words are still consumed.
//  - matrix_mode is never changed outside IDLE, so it is stable during every burst.
//  - Only one strobe (load_en/load_id_en/pop_en) is ever high in a cycle.
//  - data_in holds its last value outside ISSUE.
//  - Depth counters are per mode (depth[0] modelview, depth[1] projection), range 1..STACK_DEPTH.
// TESTING
//  - Reset release, cmd LOAD_ID -> load_id_en high exactly 1 cycle at t+1.
//    matrix_mode=0; cmd_ready low at t+1, high at t+2.
//  - MODE_PJ then LOAD with words 0x3F800000+k (k=0..15, no gaps).
//    Expected: load_en 1 cycle; data_in = {w0,w1,w2,w3} .. {w12,w13,w14,w15} on 4 consecutive
//    cycles; matrix_mode=1 throughout.
//  - LOAD with word_valid toggling every other cycle -> same 4 rows.
//    First row issues the cycle after word 15 handshake.
//  - POP right after reset -> err pulse, no pop_en.
//    Then LOAD, POP -> pop_en 1 cycle, no err.
//  - STACK_DEPTH=2: two LOADs in modelview -> second LOAD consumes 16 words.
//    Expected: err pulse, no load_en. Then MODE_PJ, LOAD succeeds (independent depth).
//  - Assert reset after 3rd ISSUE cycle -> outputs at reset values immediately.
//    No further load_en/data_in change. Next LOAD after release behaves normally.
//    cmd_op=7 -> err pulse only.

Source files
------------

// File: rtl/matrix_cmd_seq.sv
// Command sequencer feeding the matrix stack controller: accepts matrix
// commands and a float word stream and packs each LOAD into four 128-bit rows.
// It drives the controller's strobes and row bus, owns matrix_mode, and keeps
// one stack-depth counter per mode to refuse overflow and underflow.
module matrix_cmd_seq #(
  parameter int unsigned STACK_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [31:0]  word_data,
  output logic         matrix_mode,
  output logic         load_id_en,
  output logic         load_en,
  output logic         pop_en,
  output logic [127:0] data_in,
  output logic         busy,
  output logic         err
);

  localparam int unsigned OP_W      = 3;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROW_W     = 128;
  localparam int unsigned LANES     = 4;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned WORDS     = ROWS * LANES;
  localparam int unsigned K_W       = 4;
  localparam int unsigned R_W       = 2;
  localparam int unsigned DEPTH_W   = $clog2(STACK_DEPTH + 1);

  localparam logic [OP_W-1:0] OP_NOP     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MODE_MV = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MODE_PJ = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOAD_ID = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LOAD    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_POP     = OP_W'(5);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PULSE   = 2'd1,
    S_COLLECT = 2'd2,
    S_ISSUE   = 2'd3
  } state_t;

  // Registered state and outputs
  state_t               r_state;
  logic [K_W-1:0]       r_k;
  logic [R_W-1:0]       r_r;
  logic                 r_mode;
  logic [DEPTH_W-1:0]   r_depth [2];
  logic [WORD_W-1:0]    r_buf   [WORDS];
  logic                 r_cmd_ready;
  logic                 r_word_ready;
  logic                 r_busy;
  logic                 r_load_id_en;
  logic                 r_load_en;
  logic                 r_pop_en;
  logic                 r_err;
  logic [ROW_W-1:0]     r_data;

  // Next-state values
  state_t               w_state_nxt;
  logic [K_W-1:0]       w_k_nxt;
  logic [R_W-1:0]       w_r_nxt;
  logic                 w_mode_nxt;
  logic [DEPTH_W-1:0]   w_depth_nxt [2];
  logic                 w_cmd_ready_nxt;
  logic                 w_word_ready_nxt;
  logic                 w_busy_nxt;
  logic                 w_load_id_nxt;
  logic                 w_load_nxt;
  logic                 w_pop_nxt;
  logic                 w_err_nxt;
  logic [ROW_W-1:0]     w_data_nxt;

  // Handshake and depth qualifiers
  logic                 w_cmd_fire;
  logic                 w_word_fire;
  logic [DEPTH_W-1:0]   w_cur_depth;
  logic                 w_can_pop;
  logic                 w_can_push;
  logic [ROW_W-1:0]     w_rows [ROWS];

  assign w_cmd_fire  = cmd_valid && r_cmd_ready;
  assign w_word_fire = word_valid && r_word_ready;
  assign w_cur_depth = r_depth[r_mode];
  assign w_can_pop   = (w_cur_depth > DEPTH_W'(1));
  assign w_can_push  = (w_cur_depth < DEPTH_W'(STACK_DEPTH));

  // Row view of the word buffer; lane 0 lands in the top 32 bits
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      w_rows[i] = {r_buf[LANES*i + 0], r_buf[LANES*i + 1],
                   r_buf[LANES*i + 2], r_buf[LANES*i + 3]};
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k;
    w_r_nxt        = r_r;
    w_mode_nxt     = r_mode;
    w_depth_nxt[0] = r_depth[0];
    w_depth_nxt[1] = r_depth[1];
    w_load_id_nxt  = 1'b0;
    w_load_nxt     = 1'b0;
    w_pop_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_data_nxt     = r_data;

    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          unique case (cmd_op)
            OP_NOP:     w_state_nxt = S_IDLE;
            OP_MODE_MV: w_mode_nxt  = 1'b0;
            OP_MODE_PJ: w_mode_nxt  = 1'b1;
            OP_LOAD_ID: begin
              w_state_nxt   = S_PULSE;
              w_load_id_nxt = 1'b1;
            end
            OP_LOAD: begin
              w_state_nxt = S_COLLECT;
              w_k_nxt     = K_W'(0);
            end
            OP_POP: begin
              if (w_can_pop) begin
                w_state_nxt         = S_PULSE;
                w_pop_nxt           = 1'b1;
                w_depth_nxt[r_mode] = w_cur_depth - DEPTH_W'(1);
              end else begin
                w_err_nxt = 1'b1;
              end
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end

      S_PULSE: w_state_nxt = S_IDLE;

      S_COLLECT: begin
        if (w_word_fire) begin
          w_k_nxt = r_k + K_W'(1);
          if (r_k == K_W'(WORDS - 1)) begin
            if (w_can_push) begin
              // Row 0 goes out with the load_en strobe; rows 1..3 follow
              w_state_nxt         = S_ISSUE;
              w_r_nxt             = R_W'(0);
              w_load_nxt          = 1'b1;
              w_data_nxt          = w_rows[0];
              w_depth_nxt[r_mode] = w_cur_depth + DEPTH_W'(1);
            end else begin
              // Stack full: words were drained, nothing is sent
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end
          end
        end
      end

      S_ISSUE: begin
        if (r_r == R_W'(ROWS - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_r_nxt    = r_r + R_W'(1);
          w_data_nxt = w_rows[r_r + R_W'(1)];
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_cmd_ready_nxt  = (w_state_nxt == S_IDLE);
    w_word_ready_nxt = (w_state_nxt == S_COLLECT);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
  end

  // State, control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_k          <= K_W'(0);
      r_r          <= R_W'(0);
      r_mode       <= 1'b0;
      r_depth[0]   <= DEPTH_W'(1);
      r_depth[1]   <= DEPTH_W'(1);
      r_cmd_ready  <= 1'b1;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_load_id_en <= 1'b0;
      r_load_en    <= 1'b0;
      r_pop_en     <= 1'b0;
      r_err        <= 1'b0;
      r_data       <= ROW_W'(0);
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_r          <= w_r_nxt;
      r_mode       <= w_mode_nxt;
      r_depth[0]   <= w_depth_nxt[0];
      r_depth[1]   <= w_depth_nxt[1];
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_word_ready <= w_word_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_load_id_en <= w_load_id_nxt;
      r_load_en    <= w_load_nxt;
      r_pop_en     <= w_pop_nxt;
      r_err        <= w_err_nxt;
      r_data       <= w_data_nxt;
    end
  end

  // Word buffer; contents only matter after a full 16-word collect
  always_ff @(posedge clk) begin
    if (w_word_fire) begin
      r_buf[r_k] <= word_data;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign word_ready  = r_word_ready;
  assign busy        = r_busy;
  assign matrix_mode = r_mode;
  assign load_id_en  = r_load_id_en;
  assign load_en     = r_load_en;
  assign pop_en      = r_pop_en;
  assign err         = r_err;
  assign data_in     = r_data;

endmodule

// File: tb/tb_matrix_cmd_seq.sv
// Bench for matrix_cmd_seq: directed scenarios plus random command traffic,
// checked cycle by cycle against a transaction-level model of the sequencer.
module tb_matrix_cmd_seq;

  localparam int unsigned SD = 2;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic         matrix_mode;
  logic         load_id_en;
  logic         load_en;
  logic         pop_en;
  logic [127:0] data_in;
  logic         busy;
  logic         err;

  matrix_cmd_seq #(.STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .matrix_mode(matrix_mode), .load_id_en(load_id_en), .load_en(load_en),
    .pop_en(pop_en), .data_in(data_in), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic         m_mode;
  int           m_depth [2];
  logic [127:0] m_data;
  logic [31:0]  words [16];

  int n_chk  = 0;
  int n_pass = 0;

  wire [7:0] w_st = {cmd_ready, word_ready, busy, load_id_en, load_en, pop_en, err, matrix_mode};

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] exp_st(input logic cr, input logic wr, input logic bz,
                                        input logic lid, input logic ld, input logic pp,
                                        input logic er);
    return {cr, wr, bz, lid, ld, pp, er, m_mode};
  endfunction

  function automatic logic [127:0] row(input int r);
    return {words[4*r], words[4*r+1], words[4*r+2], words[4*r+3]};
  endfunction

  task automatic check_cycle(input string tag, input logic [7:0] est);
    check_val({tag, "_status"}, 128'(w_st), 128'(est));
    check_val({tag, "_data"}, data_in, m_data);
  endtask

  // Present one command; returns #1 after the accepting edge (cycle t+1)
  task automatic send_cmd(input logic [2:0] op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    if (op != 3'd4) begin
      word_valid = 1'($urandom);
      word_data  = $urandom;
    end else begin
      word_valid = 1'b0;
    end
    check_val("cmd_ready_before_cmd", 128'(cmd_ready), 128'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
  endtask

  // Any non-LOAD command, two cycles checked after acceptance
  task automatic do_simple(input logic [2:0] op);
    logic [7:0] est;
    send_cmd(op);
    est = exp_st(1, 0, 0, 0, 0, 0, 0);
    case (op)
      3'd0: ;
      3'd1: m_mode = 1'b0;
      3'd2: m_mode = 1'b1;
      3'd3: est = exp_st(0, 0, 1, 1, 0, 0, 0);
      3'd5: begin
        if (m_depth[m_mode] > 1) begin
          m_depth[m_mode]--;
          est = exp_st(0, 0, 1, 0, 0, 1, 0);
        end else begin
          est = exp_st(1, 0, 0, 0, 0, 0, 1);
        end
      end
      default: est = exp_st(1, 0, 0, 0, 0, 0, 1);
    endcase
    if (op == 3'd1 || op == 3'd2) est = exp_st(1, 0, 0, 0, 0, 0, 0);
    check_cycle($sformatf("op%0d_c1", op), est);
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    check_cycle($sformatf("op%0d_c2", op), exp_st(1, 0, 0, 0, 0, 0, 0));
  endtask

  // LOAD with gap style 0 none, 1 toggling, 2 random; checks nsamp cycles after last word
  task automatic do_load(input int gap, input int nsamp);
    int  k;
    int  it;
    bit  ok;
    logic [7:0] est;
    for (int i = 0; i < 16; i++) words[i] = (gap == 0) ? 32'h3F80_0000 + 32'(i) : $urandom;
    send_cmd(3'd4);
    k  = 0;
    it = 0;
    while (k < 16) begin
      check_cycle("collect", exp_st(0, 1, 1, 0, 0, 0, 0));
      case (gap)
        0:       word_valid = 1'b1;
        1:       word_valid = (it % 2) == 1;
        default: word_valid = 1'($urandom);
      endcase
      word_data = word_valid ? words[k] : $urandom;
      it++;
      @(posedge clk);
      if (word_valid) k++;
      #1;
    end
    word_valid = 1'b0;
    ok = m_depth[m_mode] < SD;
    for (int j = 1; j <= nsamp; j++) begin
      if (ok) begin
        if (j <= 4) begin
          m_data = row(j - 1);
          est = exp_st(0, 0, 1, 0, j == 1, 0, 0);
        end else begin
          est = exp_st(1, 0, 0, 0, 0, 0, 0);
        end
      end else begin
        est = exp_st(1, 0, 0, 0, 0, 0, j == 1);
      end
      check_cycle($sformatf("load_u%0d", j), est);
      if (j < nsamp) begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) m_depth[m_mode]++;
  endtask

  task automatic model_reset();
    m_mode     = 1'b0;
    m_depth[0] = 1;
    m_depth[1] = 1;
    m_data     = '0;
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    word_valid = 1'b0;
    word_data  = '0;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cycle("reset", exp_st(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_cycle("after_release", exp_st(1, 0, 0, 0, 0, 0, 0));

    // Strobe, underflow and per-mode depth scenarios
    do_simple(3'd3);
    do_simple(3'd5);
    do_load(2, 5);
    do_load(2, 5);
    do_simple(3'd2);
    do_load(0, 5);
    do_simple(3'd5);
    do_simple(3'd1);
    do_simple(3'd5);
    do_load(1, 5);
    do_simple(3'd5);

    // Asynchronous reset during the third row of a burst
    do_simple(3'd2);
    do_load(2, 3);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_cycle("reset_mid_issue", exp_st(1, 0, 0, 0, 0, 0, 0));
    repeat (3) begin
      @(posedge clk);
      #1;
      check_cycle("reset_hold", exp_st(1, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b1;
    do_simple(3'd5);
    do_load(0, 5);
    do_simple(3'd7);
    do_simple(3'd6);
    do_simple(3'd0);

    // Random command traffic
    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd4) do_load(int'($urandom_range(0, 2)), 5);
      else            do_simple(op);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
